// File: rtl/rng_pkg.sv
// Shared constants for the 32-bit Fibonacci LFSR random bit generator.
// Holds width, tap positions and the seed helpers.
package rng_pkg;

  localparam int LFSR_WIDTH = 32;

  localparam int TAP0 = 31;
  localparam int TAP1 = 21;
  localparam int TAP2 = 1;
  localparam int TAP3 = 0;

  localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 32'h0000_0001;
  localparam logic [LFSR_WIDTH-1:0] LOCKUP_SEED  = 32'h0000_0001;

  // All-zero is the LFSR's dead state, so never load it.
  function automatic logic [LFSR_WIDTH-1:0] seed_fix(
    input logic [LFSR_WIDTH-1:0] s
  );
    return (s == '0) ? LOCKUP_SEED : s;
  endfunction

endpackage

// File: rtl/lfsr32_step.sv
// One combinational step of the x^32+x^22+x^2+x+1 Fibonacci LFSR.
// An all-zero state reloads the lock-up seed instead of shifting.
module lfsr32_step
  import rng_pkg::*;
(
  input  logic [LFSR_WIDTH-1:0] i_s,
  output logic [LFSR_WIDTH-1:0] o_next,
  output logic                  o_fb
);

  logic w_fb;
  logic w_zero;

  assign w_fb   = i_s[TAP0] ^ i_s[TAP1]
                ^ i_s[TAP2] ^ i_s[TAP3];
  assign w_zero = (i_s == '0);
  assign o_fb   = w_fb;
  assign o_next = w_zero ? LOCKUP_SEED
                : {i_s[LFSR_WIDTH-2:0], w_fb};

endmodule

// File: rtl/rng_lfsr.sv
// Random bit generator: one LFSR bit per accepted start, done one cycle later.
// Registers and control only; the step logic lives in lfsr32_step.
module rng_lfsr
  import rng_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [31:0] SEED  = 32'h0000_0001
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic result,
  output logic done
);

  localparam logic [LFSR_WIDTH-1:0] SEED_FIX = seed_fix(SEED);

  logic [WIDTH-1:0]      r_s;
  logic                  r_result;
  logic                  r_done;
  logic [LFSR_WIDTH-1:0] w_next;
  logic                  w_fb;

  lfsr32_step u_step (
    .i_s    (r_s),
    .o_next (w_next),
    .o_fb   (w_fb)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s      <= SEED_FIX;
      r_result <= 1'b0;
      r_done   <= 1'b0;
    end else if (start) begin
      r_s      <= w_next;
      r_result <= w_fb;
      r_done   <= 1'b1;
    end else begin
      r_done   <= 1'b0;
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: tb/tb_rng_lfsr.sv
// Directed-vector bench for rng_lfsr and lfsr32_step.
// Table run, long sequence vs software model, zero-seed and zero-guard checks.
module tb_rng_lfsr;

  logic clk;
  logic reset_n, start, result, done;
  logic rst0, start0, result0, done0;
  logic [31:0] st_in, st_next;
  logic        st_fb;

  int checks   = 0;
  int failures = 0;

  rng_lfsr dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .result  (result),
    .done    (done)
  );

  rng_lfsr #(.WIDTH(32), .SEED(32'h0)) dut0 (
    .clk     (clk),
    .reset_n (rst0),
    .start   (start0),
    .result  (result0),
    .done    (done0)
  );

  lfsr32_step u_st (
    .i_s    (st_in),
    .o_next (st_next),
    .o_fb   (st_fb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        result;
    logic        done;
    logic [31:0] s;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s);
    @(negedge clk);
    reset_n = r;
    start   = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] m;
    logic        fb;
    int          ones;

    reset_n = 1'b0; start = 1'b0;
    rst0 = 1'b0; start0 = 1'b0;
    st_in = 32'h0;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h1};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h3};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h6};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hD};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1B};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h1B};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h1B};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h36};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h36};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h3};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h6};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hD};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h1B};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h1};

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rst_n, tbl[i].start);
      chk($sformatf("v%0d.result", i), {31'b0, result},
          {31'b0, tbl[i].result});
      chk($sformatf("v%0d.done", i), {31'b0, done},
          {31'b0, tbl[i].done});
      chk($sformatf("v%0d.s", i), dut.r_s, tbl[i].s);
    end

    // Long run against a software model
    cyc(1'b0, 1'b0);
    m = 32'h1;
    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, 1'b1);
      fb = m[31] ^ m[21] ^ m[1] ^ m[0];
      m  = {m[30:0], fb};
      if (fb) ones++;
      chk($sformatf("long%0d.result", i), {31'b0, result},
          {31'b0, fb});
      chk($sformatf("long%0d.done", i), {31'b0, done}, 32'h1);
      if (i % 100 == 99)
        chk($sformatf("long%0d.s", i), dut.r_s, m);
    end
    checks++;
    if (ones < 440 || ones > 560) begin
      failures++;
      $display("FAIL ones_count: got %0d expected 440..560", ones);
    end
    cyc(1'b1, 1'b0);
    chk("long_stop.done", {31'b0, done}, 32'h0);
    chk("long_stop.result", {31'b0, result}, {31'b0, fb});

    // SEED=0 instance: reset must load 1, then shift normally
    @(negedge clk);
    rst0 = 1'b0; start0 = 1'b1;
    @(posedge clk); #1;
    chk("seed0.reset_s", dut0.r_s, 32'h1);
    chk("seed0.reset_done", {31'b0, done0}, 32'h0);
    @(negedge clk);
    rst0 = 1'b1; start0 = 1'b1;
    @(posedge clk); #1;
    chk("seed0.s1", dut0.r_s, 32'h3);
    chk("seed0.r1", {31'b0, result0}, 32'h1);
    chk("seed0.d1", {31'b0, done0}, 32'h1);
    @(negedge clk);
    start0 = 1'b0;

    // Zero guard and tap positions on the step logic
    st_in = 32'h0; #1;
    chk("step0.next", st_next, 32'h1);
    chk("step0.fb", {31'b0, st_fb}, 32'h0);
    st_in = 32'h8000_0000; #1;
    chk("step31.next", st_next, 32'h1);
    chk("step31.fb", {31'b0, st_fb}, 32'h1);
    st_in = 32'h0020_0000; #1;
    chk("step21.next", st_next, 32'h0040_0001);
    st_in = 32'h0000_0002; #1;
    chk("step1.next", st_next, 32'h0000_0005);
    st_in = 32'h8020_0003; #1;
    chk("step4tap.fb", {31'b0, st_fb}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rng_lfsr.md
RNG_LFSR -- requirements
Module: rng_lfsr

Interface
REQ-001 Parameter WIDTH, default 32, LFSR state width; only 32 is supported.
REQ-002 Parameter SEED, default 32'h0000_0001, LFSR reset state; a zero value SHALL be replaced by 32'h0000_0001.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-005 start  input  1  request one random bit; may be held high to request one bit per cycle.
REQ-006 result  output  1  most recently generated random bit, registered.
REQ-007 done  output  1  one-cycle strobe marking result valid for the request accepted on the previous edge.

Function
REQ-008 The generator SHALL be a 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, maximal period 2^32-1.
REQ-009 Feedback SHALL be fb = s[31]^s[21]^s[1]^s[0], where s is the current state.
REQ-010 A rising edge with reset_n=1 and start=1 SHALL set s <= {s[30:0], fb}, result <= fb and done <= 1.
REQ-011 A rising edge with reset_n=1 and start=0 SHALL hold s and result and set done <= 0.
REQ-012 Latency SHALL be one cycle: a start sampled at edge N makes done=1 and result valid after edge N.
REQ-013 There is no busy state: start SHALL be accepted every cycle, so continuous start gives one new bit and done=1 every cycle.
REQ-014 There is no handshake back-pressure; done SHALL NOT depend on any acknowledge.
REQ-015 If s is ever all-zero, the next start SHALL reload s with 32'h0000_0001 instead of shifting, so the generator cannot lock up.
REQ-016 result SHALL be unchanged at every edge without start.

Reset
REQ-017 On an edge with reset_n=0: s <= SEED (zero-corrected), result <= 0, done <= 0; start is ignored on that edge.
REQ-018 A reset asserted during continuous start SHALL abort the sequence; the first start after reset release SHALL restart the sequence from SEED.

Structure
REQ-019 The shared package rng_pkg SHALL hold LFSR_WIDTH=32, the tap positions (31,21,1,0) and DEFAULT_SEED.
REQ-020 One sub-module is natural: lfsr32_step, which is combinational and maps s to {next_s, fb}, including the zero guard; rng_lfsr holds the registers and control.
REQ-021 The design SHALL contain no latches, and no combinational path from start to result or to done.

Verification
REQ-022 Reset with the default SEED, then hold start=1 for 4 cycles -> result = 1,0,1,1; done=1 on each; s = 0x3, 0x6, 0xD, 0x1B.
REQ-023 Apply reset_n=0 for one edge -> result=0, done=0, s=SEED; with start=0 afterwards, done stays 0 and result holds.
REQ-024 Pulse start for one cycle, then start=0 -> done high for exactly one cycle; result holds its value while start=0.
REQ-025 Hold start=1 for 1000 cycles -> 1000 done strobes; the sequence bit-matches a software LFSR model; the ones count is 500±60.
REQ-026 Force s=0 (or set SEED=0), then start -> s becomes 32'h0000_0001 and no lock-up occurs; with SEED=0, reset loads 0x1.
REQ-027 Assert reset mid-stream for one cycle, then restart -> the sequence repeats from 1,0,1,1.
